// File: rtl/s100_io_port_responder.sv
// S-100 I/O slave decoding four ports at PORT_BASE; pSYNC pin to DECODE in 3 clk, then WAIT_CYCLES of RDY low.
// Backpressure on the bus is RDY only; a stalled strobe phase aborts after TIMEOUT clk and sets the sticky tmo flag.
module s100_io_port_responder #(
    parameter logic [7:0] PORT_BASE   = 8'h40,
    parameter int         WAIT_CYCLES = 2,
    parameter int         TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [15:0] s100_adr,
    input  logic        s100_pSYNC,
    input  logic        s100_pDBIN,
    input  logic        s100_n_pWR,
    input  logic        s100_sINP,
    input  logic        s100_sOUT,
    input  logic [7:0]  s100_DO,
    output logic [7:0]  s100_DI,
    output logic        s100_DI_oe,
    output logic        s100_rdy,
    input  logic [7:0]  switchIn,
    output logic [7:0]  portLatch,
    output logic        writeStrobe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);
    localparam logic [3:0] WAIT_ID   = 4'(WAIT_CYCLES);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic        r_psync_d;
    logic        r_pdbin_d;
    logic [1:0]  r_port;
    logic        r_is_rd;
    logic [3:0]  r_wcnt;
    logic [7:0]  r_tcnt;
    logic [7:0]  r_cnt;
    logic        r_tmo;
    logic [7:0]  r_di;
    logic        r_di_oe;
    logic        r_rdy;
    logic [7:0]  r_latch;
    logic        r_wstrobe;

    logic        w_psync_rise;
    logic        w_pdbin;
    logic        w_pdbin_fall;
    logic        w_npwr;
    logic        w_sinp;
    logic        w_sout;
    logic        w_adr_hit;
    logic        w_match;
    logic [7:0]  w_rd_mux;
    logic        w_unused;

    // Synchronizer bit order: {sOUT, sINP, n_pWR, pDBIN, pSYNC}
    assign w_psync_rise = r_sync2[0] & ~r_psync_d;
    assign w_pdbin      = r_sync2[1];
    assign w_pdbin_fall = ~r_sync2[1] & r_pdbin_d;
    assign w_npwr       = r_sync2[2];
    assign w_sinp       = r_sync2[3];
    assign w_sout       = r_sync2[4];
    assign w_adr_hit    = (s100_adr[7:2] == PORT_BASE[7:2]);
    assign w_match      = w_adr_hit & (w_sinp ^ w_sout);
    assign w_unused     = ^s100_adr[15:8];

    always_comb begin
        w_rd_mux = 8'h00;
        case (s100_adr[1:0])
            2'd0:    w_rd_mux = r_latch;
            2'd1:    w_rd_mux = switchIn;
            2'd2:    w_rd_mux = {WAIT_ID, 3'b000, r_tmo};
            default: w_rd_mux = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state   <= S_IDLE;
            r_sync1   <= 5'b00100;
            r_sync2   <= 5'b00100;
            r_psync_d <= 1'b0;
            r_pdbin_d <= 1'b0;
            r_port    <= 2'd0;
            r_is_rd   <= 1'b0;
            r_wcnt    <= 4'd0;
            r_tcnt    <= 8'd0;
            r_cnt     <= 8'd0;
            r_tmo     <= 1'b0;
            r_di      <= 8'h00;
            r_di_oe   <= 1'b0;
            r_rdy     <= 1'b1;
            r_latch   <= 8'h00;
            r_wstrobe <= 1'b0;
        end else begin
            r_sync1   <= {s100_sOUT, s100_sINP, s100_n_pWR, s100_pDBIN, s100_pSYNC};
            r_sync2   <= r_sync1;
            r_psync_d <= r_sync2[0];
            r_pdbin_d <= r_sync2[1];
            r_wstrobe <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_psync_rise) begin
                        r_state <= S_DECODE;
                        // Load read data early so DI settles a clock before DI_oe rises
                        if (w_match && w_sinp) begin
                            r_di <= w_rd_mux;
                        end
                    end
                end
                S_DECODE: begin
                    if (w_match) begin
                        r_port  <= s100_adr[1:0];
                        r_is_rd <= w_sinp;
                        r_tcnt  <= 8'd0;
                        r_wcnt  <= WAIT_LOAD;
                        r_di_oe <= w_sinp;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= w_sinp ? S_READ : S_WRITE;
                        end else begin
                            r_state <= S_WAIT;
                            r_rdy   <= 1'b0;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_wcnt == 4'd0) begin
                        r_rdy   <= 1'b1;
                        r_state <= r_is_rd ? S_READ : S_WRITE;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                S_READ: begin
                    if (w_pdbin_fall) begin
                        r_di_oe <= 1'b0;
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= S_DONE;
                    end else if (r_tcnt == TMO_LAST) begin
                        r_di_oe <= 1'b0;
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_WRITE: begin
                    if (!w_npwr) begin
                        r_state <= S_DONE;
                        r_cnt   <= r_cnt + 8'd1;
                        case (r_port)
                            2'd0: begin
                                r_latch   <= s100_DO;
                                r_wstrobe <= 1'b1;
                            end
                            2'd2: begin
                                if (s100_DO[0]) begin
                                    r_tmo <= 1'b0;
                                end
                            end
                            2'd3:    r_cnt <= s100_DO;
                            default: ;
                        endcase
                    end else if (r_tcnt == TMO_LAST) begin
                        r_tmo   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_DONE: begin
                    if (!w_pdbin && w_npwr) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s100_DI     = r_di;
    assign s100_DI_oe  = r_di_oe;
    assign s100_rdy    = r_rdy;
    assign portLatch   = r_latch;
    assign writeStrobe = r_wstrobe;

endmodule

// File: tb/tb_s100_io_port_responder.sv
// Directed bench for s100_io_port_responder: bus IN/OUT cycles with hand-computed expectations.
module tb_s100_io_port_responder;

    logic        clk = 1'b0;
    logic        n_reset;
    logic [15:0] s100_adr;
    logic        s100_pSYNC, s100_pDBIN, s100_n_pWR, s100_sINP, s100_sOUT;
    logic [7:0]  s100_DO, s100_DI, switchIn, portLatch;
    logic        s100_DI_oe, s100_rdy, writeStrobe;

    int n_checks = 0;
    int n_fail   = 0;

    s100_io_port_responder #(
        .PORT_BASE   (8'h40),
        .WAIT_CYCLES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .n_reset     (n_reset),
        .s100_adr    (s100_adr),
        .s100_pSYNC  (s100_pSYNC),
        .s100_pDBIN  (s100_pDBIN),
        .s100_n_pWR  (s100_n_pWR),
        .s100_sINP   (s100_sINP),
        .s100_sOUT   (s100_sOUT),
        .s100_DO     (s100_DO),
        .s100_DI     (s100_DI),
        .s100_DI_oe  (s100_DI_oe),
        .s100_rdy    (s100_rdy),
        .switchIn    (switchIn),
        .portLatch   (portLatch),
        .writeStrobe (writeStrobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: status+pSYNC, 10 clk of address/wait phase, 8 clk of strobe phase, 4 clk idle.
    task automatic access(input string tag, input logic is_in, input logic [7:0] a,
                          input logic [7:0] d, input logic sin, input logic sout,
                          input int e_rdy, input int e_oe, input int e_ws, input logic [7:0] e_di);
        int rdy_lo = 0;
        int oe_hi  = 0;
        int ws     = 0;
        int ws_at  = 0;
        logic [7:0] di = 8'h00;
        s100_adr   = {8'h00, a};
        s100_sINP  = sin;
        s100_sOUT  = sout;
        s100_DO    = d;
        s100_pSYNC = 1'b1;
        s100_pDBIN = is_in;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 1) s100_pSYNC = 1'b0;
            if (!s100_rdy) rdy_lo++;
            if (s100_DI_oe) begin
                oe_hi++;
                di = s100_DI;
            end
            if (writeStrobe) begin
                ws++;
                if (ws_at == 0) ws_at = i - 9;
            end
            if (i == 9) begin
                if (is_in) s100_pDBIN = 1'b0;
                else       s100_n_pWR = 1'b0;
            end
        end
        s100_n_pWR = 1'b1;
        s100_sINP  = 1'b0;
        s100_sOUT  = 1'b0;
        repeat (4) tick();
        check({tag, "_rdy_low"}, 16'(rdy_lo), 16'(e_rdy));
        check({tag, "_oe_cyc"},  16'(oe_hi),  16'(e_oe));
        check({tag, "_wstrobe"}, 16'(ws),     16'(e_ws));
        check({tag, "_di"},      {8'h00, di}, {8'h00, e_di});
        if (e_ws != 0) check({tag, "_ws_latency"}, 16'(ws_at), 16'd3);
    endtask

    initial begin
        n_reset    = 1'b0;
        s100_adr   = 16'h0000;
        s100_pSYNC = 1'b0;
        s100_pDBIN = 1'b0;
        s100_n_pWR = 1'b1;
        s100_sINP  = 1'b0;
        s100_sOUT  = 1'b0;
        s100_DO    = 8'h00;
        switchIn   = 8'hC3;
        repeat (3) tick();
        check("rst_di",    {8'h00, s100_DI}, 16'h0000);
        check("rst_oe",    16'(s100_DI_oe), 16'd0);
        check("rst_rdy",   16'(s100_rdy), 16'd1);
        check("rst_latch", {8'h00, portLatch}, 16'h0000);
        check("rst_ws",    16'(writeStrobe), 16'd0);
        n_reset = 1'b1;
        repeat (3) tick();

        // Basic write/read; counter 0 -> 1 on the OUT, reads return pre-increment value
        access("out40", 1'b0, 8'h40, 8'h5A, 1'b0, 1'b1, 2, 0, 1, 8'h00);
        check("latch_5a", {8'h00, portLatch}, 16'h005A);
        access("in43a", 1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h01);
        access("in41",  1'b1, 8'h41, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'hC3);
        access("in42a", 1'b1, 8'h42, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h20);

        // Non-matching cycles must leave RDY, DI_oe, latch and counter untouched
        access("out44",  1'b0, 8'h44, 8'h11, 1'b0, 1'b1, 0, 0, 0, 8'h00);
        access("in3f",   1'b1, 8'h3F, 8'h00, 1'b1, 1'b0, 0, 0, 0, 8'h00);
        access("both40", 1'b1, 8'h40, 8'h00, 1'b1, 1'b1, 0, 0, 0, 8'h00);
        check("latch_hold", {8'h00, portLatch}, 16'h005A);
        access("in43b", 1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h04);

        // Counter load and wrap
        access("out43ff", 1'b0, 8'h43, 8'hFF, 1'b0, 1'b1, 2, 0, 0, 8'h00);
        access("in43ff",  1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'hFF);
        access("in43wr",  1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h00);
        access("out4310", 1'b0, 8'h43, 8'h10, 1'b0, 1'b1, 2, 0, 0, 8'h00);
        access("in4310",  1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h10);
        access("out41",   1'b0, 8'h41, 8'h77, 1'b0, 1'b1, 2, 0, 0, 8'h00);
        check("latch_ro", {8'h00, portLatch}, 16'h005A);

        // Decoded IN with pDBIN never asserted: READ entered on clk 6, aborted after 16 clk
        s100_adr   = 16'h0041;
        s100_sINP  = 1'b1;
        s100_pSYNC = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) s100_pSYNC = 1'b0;
        end
        check("tmo_rd_oe",  16'(s100_DI_oe), 16'd1);
        check("tmo_rd_rdy", 16'(s100_rdy), 16'd1);
        repeat (15) tick();
        check("tmo_oe_hold", 16'(s100_DI_oe), 16'd1);
        tick();
        check("tmo_abort_oe", 16'(s100_DI_oe), 16'd0);
        s100_sINP = 1'b0;
        repeat (4) tick();

        access("in42tmo",  1'b1, 8'h42, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h21);
        access("out42clr", 1'b0, 8'h42, 8'h01, 1'b0, 1'b1, 2, 0, 0, 8'h00);
        access("in42clr",  1'b1, 8'h42, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h20);
        access("in43tmo",  1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h15);

        // Reset asserted while in WAIT of a read
        s100_adr   = 16'h0041;
        s100_sINP  = 1'b1;
        s100_pDBIN = 1'b1;
        s100_pSYNC = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) s100_pSYNC = 1'b0;
        end
        check("midwait_rdy", 16'(s100_rdy), 16'd0);
        check("midwait_oe",  16'(s100_DI_oe), 16'd1);
        n_reset = 1'b0;
        tick();
        check("mrst_rdy",   16'(s100_rdy), 16'd1);
        check("mrst_oe",    16'(s100_DI_oe), 16'd0);
        check("mrst_latch", {8'h00, portLatch}, 16'h0000);
        s100_pDBIN = 1'b0;
        s100_sINP  = 1'b0;
        tick();
        n_reset = 1'b1;
        repeat (4) tick();
        access("post_out40", 1'b0, 8'h40, 8'hA5, 1'b0, 1'b1, 2, 0, 1, 8'h00);
        check("post_latch", {8'h00, portLatch}, 16'h00A5);
        access("post_in43",  1'b1, 8'h43, 8'h00, 1'b1, 1'b0, 2, 9, 0, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
